// File: rtl/arb_mux_pkg.sv
// Shared constants and width helpers for the arbitrated stream multiplexer.
package arb_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // A channel index is never narrower than one bit, even for a single input.
  function automatic int idx_w(input int m);
    return (m > 1) ? clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority from channel 0, or a round-robin
// search that starts at ptr and wraps modulo M.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int M    = 4,
  parameter int MODE = MODE_RR,
  parameter int CW   = idx_w(M)
) (
  input  logic [M-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [M-1:0]  gnt_onehot,
  output logic [CW-1:0] gnt_idx
);

  int   start;
  int   c;
  logic found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    c          = 0;
    start      = (MODE == MODE_RR && int'(ptr) < M) ? int'(ptr) : 0;
    for (int s = 0; s < M; s++) begin
      c = start + s;
      if (c >= M) c = c - M;
      if (!found && req[c]) begin
        found         = 1'b1;
        gnt_onehot[c] = 1'b1;
        gnt_idx       = CW'(c);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// M-input registered stream multiplexer: arbiter picks one valid producer,
// its beat is captured in a single output register with valid/ready flow.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int MODE = MODE_RR,
  parameter int CW   = idx_w(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  input  logic [M*N-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [CW-1:0]   out_ch
);

  logic [M-1:0]  gnt_onehot;
  logic [CW-1:0] gnt_idx;
  logic [CW-1:0] rr_ptr;
  logic          load_en;
  logic          take;
  logic [N-1:0]  sel_data;

  logic          vld_p1;
  logic [N-1:0]  data_p1;
  logic [CW-1:0] ch_p1;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] idx);
    return (int'(idx) >= M - 1) ? '0 : CW'(int'(idx) + 1);
  endfunction

  rr_arbiter #(.M(M), .MODE(MODE), .CW(CW)) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  // Stage p0: grant and handshake; rst_n gates in_ready so nothing is offered in reset.
  assign load_en  = !vld_p1 || out_ready;
  assign take     = rst_n && load_en && (|in_valid);
  assign in_ready = gnt_onehot & {M{take}};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < M; i++) begin
      sel_data = sel_data | (in_data[i*N +: N] & {N{gnt_onehot[i]}});
    end
  end

  // Stage p1: output register; data and channel hold when the beat drains with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      rr_ptr  <= '0;
    end else if (take) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      ch_p1   <= gnt_idx;
      if (MODE == MODE_RR) rr_ptr <= wrap_inc(gnt_idx);
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux across four configurations (RR M=4, fixed M=4,
// RR M=3, RR M=1 N=8) with randomized producers and consumer stalls.
module tb_arb_mux;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   dense = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  event rst_hit;

  always #5 clk = ~clk;

  function automatic int cfg_m(input int k);
    case (k)
      0, 1:    return 4;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_n(input int k);
    return (k == 3) ? 8 : 32;
  endfunction

  function automatic int cfg_mode(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_cfg
    localparam int MK    = cfg_m(k);
    localparam int NK    = cfg_n(k);
    localparam int MODEK = cfg_mode(k);
    localparam int CWK   = (MK > 1) ? $clog2(MK) : 1;

    logic [MK-1:0]    in_valid;
    logic [MK-1:0]    in_ready;
    logic [MK*NK-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [NK-1:0]    out_data;
    logic [CWK-1:0]   out_ch;

    beat_t sbq[$];
    bit    mvld = 1'b0;

    arb_mux #(.N(NK), .M(MK), .MODE(MODEK)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
    );

    // Producers, consumer, and the reference arbitration model.
    initial begin : drv
      int          ptr;
      int          g;
      int          acc;
      int          stall;
      logic [MK-1:0] exp_rdy;
      logic [31:0] rnd;
      beat_t       b;
      ptr = 0; acc = -1; stall = 0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (acc >= 0) in_valid[acc] = 1'b0;
        acc = -1;
        for (int i = 0; i < MK; i++) begin
          if (!in_valid[i] && (dense || $urandom_range(99) < 45)) begin
            rnd = $urandom;
            in_valid[i] = 1'b1;
            in_data[i*NK +: NK] = rnd[NK-1:0];
          end
        end
        if (dense) begin
          out_ready = 1'b1;
        end else begin
          if (stall == 0 && $urandom_range(19) == 0) stall = 5;
          if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
          end else begin
            out_ready = ($urandom_range(99) < 60) ? 1'b1 : 1'b0;
          end
        end
        g = -1;
        if (rst_n && (!mvld || out_ready)) begin
          for (int s = 0; s < MK; s++) begin
            int c;
            c = (MODEK == 1) ? (ptr + s) % MK : s;
            if (g < 0 && in_valid[c]) g = c;
          end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1;
        vectors++;
        if (in_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL in_ready cfg%0d: got %b expected %b", k, in_ready, exp_rdy);
        end
        @(posedge clk);
        if (!rst_n) begin
          mvld = 1'b0;
          ptr  = 0;
          sbq.delete();
        end else if (g >= 0) begin
          b = '0;
          b.d[NK-1:0] = in_data[g*NK +: NK];
          b.c = 8'(g);
          sbq.push_back(b);
          mvld = 1'b1;
          if (MODEK == 1) ptr = (g + 1) % MK;
          acc = g;
        end else if (out_ready) begin
          mvld = 1'b0;
        end
      end
    end

    // Pops the expected beat whenever the DUT hands one to the consumer.
    initial begin : mon
      beat_t b;
      forever begin
        @(negedge clk);
        #2;
        vectors++;
        if (out_valid !== mvld) begin
          miscompares++;
          $display("FAIL out_valid cfg%0d: got %b expected %b", k, out_valid, mvld);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          vectors++;
          if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL beat cfg%0d: got data %h ch %0d expected no beat", k, out_data, out_ch);
          end else begin
            b = sbq.pop_front();
            if (out_data !== b.d[NK-1:0] || out_ch !== b.c[CWK-1:0]) begin
              miscompares++;
              $display("FAIL beat cfg%0d: got data %h ch %0d expected data %h ch %0d",
                       k, out_data, out_ch, b.d[NK-1:0], b.c);
            end
          end
        end
      end
    end

    initial begin : rchk
      forever begin
        @(rst_hit);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || in_ready !== '0) begin
          miscompares++;
          $display("FAIL async_reset cfg%0d: got vld %b data %h ch %0d rdy %b expected all zero",
                   k, out_valid, out_data, out_ch, in_ready);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    dense = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    -> rst_hit;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    dense = 1'b1;
    repeat (20) @(posedge clk);
    dense = 1'b0;
    repeat (300) @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
